// File: rtl/mux_nto1_scan_if.sv
// Bus interface for mux_nto1_scan: channel data, control inputs and registered sample outputs.
// With MUX_PARITY_EN defined the interface also carries o_par.
`timescale 1ns/1ps
interface mux_nto1_scan_if #(
    parameter int unsigned N  = 8,
    parameter int unsigned W  = 1,
    parameter int unsigned SW = $clog2(N)
);
    logic [N*W-1:0] d;
    logic           en;
    logic           mode;
    logic [SW-1:0]  s;
    logic [7:0]     dwell;
    logic [W-1:0]   o;
    logic           o_valid;
    logic [SW-1:0]  cur_sel;
    logic           wrap;
`ifdef MUX_PARITY_EN
    logic           o_par;
`endif

    // Driver side: owns data and control, observes the sample outputs
    modport master (
        output d, output en, output mode, output s, output dwell,
        input  o, input o_valid, input cur_sel, input wrap
`ifdef MUX_PARITY_EN
        , input o_par
`endif
    );

    // Mux side: consumes data and control, produces the sample outputs
    modport slave (
        input  d, input en, input mode, input s, input dwell,
        output o, output o_valid, output cur_sel, output wrap
`ifdef MUX_PARITY_EN
        , output o_par
`endif
    );
endinterface

// File: rtl/mux_nto1_scan.sv
// Registered N-to-1 mux of W-bit channels with manual select or auto-scan.
// Auto-scan holds each channel dwell+1 cycles and pulses wrap on the N-1 -> 0 step.
// Optional MUX_PARITY_EN adds o_par, the registered XOR of the selected channel.
`timescale 1ns/1ps
module mux_nto1_scan #(
    parameter int unsigned N  = 8,
    parameter int unsigned W  = 1,
    parameter int unsigned SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    mux_nto1_scan_if.slave bus
);
    localparam int unsigned CW = 8;

    typedef enum logic {
        S_MAN  = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SW-1:0]   r_ch;
    logic [CW-1:0]   r_dwell_cnt;
    logic [W-1:0]    r_o;
    logic            r_valid;
    logic [SW-1:0]   r_cur_sel;
    logic            r_wrap;
    logic            r_par;

    logic [SW-1:0]   w_ch_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [SW-1:0]   w_sel;
    logic            w_sel_ok;
    logic            w_wrap_nxt;
    logic [W-1:0]    w_chan;

    // Sequencer state register; frozen while en is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_MAN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: track mode on enabled edges so scan entry is seen on the first enabled mode=1 edge
    always_comb begin
        w_state_nxt = r_state;
        if (bus.en) begin
            w_state_nxt = bus.mode ? S_SCAN : S_MAN;
        end
    end

    // Sequencer outputs: entry clear, HOLD (count) or STEP (advance channel), and channel selection
    always_comb begin
        w_ch_nxt   = r_ch;
        w_cnt_nxt  = r_dwell_cnt;
        w_wrap_nxt = 1'b0;
        w_sel      = bus.s;
        if (bus.mode) begin
            if (r_state == S_MAN) begin
                w_ch_nxt  = '0;
                w_cnt_nxt = '0;
            end else if (r_dwell_cnt == bus.dwell) begin
                w_ch_nxt   = (r_ch == SW'(N - 1)) ? '0 : r_ch + SW'(1);
                w_cnt_nxt  = '0;
                w_wrap_nxt = (r_ch == SW'(N - 1));
            end else begin
                w_cnt_nxt = r_dwell_cnt + CW'(1);
            end
            w_sel = w_ch_nxt;
        end else begin
            w_ch_nxt  = '0;
            w_cnt_nxt = '0;
        end
        w_sel_ok = ({1'b0, w_sel} < (SW + 1)'(N));
        w_chan   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (w_sel == SW'(k)) begin
                w_chan = bus.d[k*W +: W];
            end
        end
    end

    // Datapath and counter registers; en low holds values and drops the strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch        <= '0;
            r_dwell_cnt <= '0;
            r_o         <= '0;
            r_valid     <= 1'b0;
            r_cur_sel   <= '0;
            r_wrap      <= 1'b0;
            r_par       <= 1'b0;
        end else if (bus.en) begin
            r_ch        <= w_ch_nxt;
            r_dwell_cnt <= w_cnt_nxt;
            r_o         <= w_sel_ok ? w_chan : '0;
            r_valid     <= w_sel_ok;
            r_cur_sel   <= w_sel;
            r_wrap      <= w_wrap_nxt;
            r_par       <= w_sel_ok & (^w_chan);
        end else begin
            r_valid     <= 1'b0;
            r_wrap      <= 1'b0;
        end
    end

    assign bus.o       = r_o;
    assign bus.o_valid = r_valid;
    assign bus.cur_sel = r_cur_sel;
    assign bus.wrap    = r_wrap;
`ifdef MUX_PARITY_EN
    assign bus.o_par   = r_par;
`else
    logic w_par_unused;
    assign w_par_unused = r_par;
`endif
endmodule

// File: tb/tb_mux_nto1_scan.sv
// Testbench for mux_nto1_scan: N=8/W=1 and N=6/W=4 instances, manual vector table,
// scan/freeze/reset/mode-change/dwell-wrap sequences checked through an expectation queue.
`timescale 1ns/1ps
module tb_mux_nto1_scan;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mux_nto1_scan_if #(.N(8), .W(1)) if8 ();
    mux_nto1_scan_if #(.N(6), .W(4)) if6 ();

    mux_nto1_scan #(.N(8), .W(1)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));
    mux_nto1_scan #(.N(6), .W(4)) u_dut6 (.clk(clk), .rst(rst), .bus(if6));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          dut6;
        logic [3:0]  o;
        logic        v;
        logic [2:0]  sel;
        logic        wrap;
        logic [63:0] tag;
    } exp_t;

    typedef struct {
        bit         dut6;
        logic [2:0] s;
        logic [3:0] o;
        logic       v;
    } vec_t;

    exp_t q[$];
    vec_t vec[12];
    logic [7:0] m_d8;

    task automatic check(input logic [63:0] tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push(input bit dut6, input logic [3:0] o, input logic v,
                        input logic [2:0] sel, input logic wrap, input logic [63:0] tag);
        exp_t e;
        e.dut6 = dut6; e.o = o; e.v = v; e.sel = sel; e.wrap = wrap; e.tag = tag;
        q.push_back(e);
    endtask

    // Advance one clock, then compare every queued expectation against the chosen DUT
    task automatic tick();
        exp_t e;
        logic [3:0] a_o;
        logic       a_v;
        logic [2:0] a_sel;
        logic       a_wrap;
        @(posedge clk);
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.dut6) begin
                a_o = if6.o; a_v = if6.o_valid; a_sel = if6.cur_sel; a_wrap = if6.wrap;
            end else begin
                a_o = {3'b000, if8.o}; a_v = if8.o_valid; a_sel = if8.cur_sel; a_wrap = if8.wrap;
            end
            checks++;
            if ({a_o, a_v, a_sel, a_wrap} !== {e.o, e.v, e.sel, e.wrap}) begin
                failures++;
                $display("FAIL %s: got o=%0h v=%0b sel=%0d wrap=%0b expected o=%0h v=%0b sel=%0d wrap=%0b at %0t",
                         e.tag, a_o, a_v, a_sel, a_wrap, e.o, e.v, e.sel, e.wrap, $time);
            end
        end
    endtask

    initial begin
        int sel;
        checks   = 0;
        failures = 0;
        m_d8     = 8'd89;

        vec[0]  = '{1'b0, 3'd0, 4'h1, 1'b1};
        vec[1]  = '{1'b0, 3'd1, 4'h0, 1'b1};
        vec[2]  = '{1'b0, 3'd2, 4'h0, 1'b1};
        vec[3]  = '{1'b0, 3'd3, 4'h1, 1'b1};
        vec[4]  = '{1'b0, 3'd4, 4'h1, 1'b1};
        vec[5]  = '{1'b0, 3'd5, 4'h0, 1'b1};
        vec[6]  = '{1'b0, 3'd6, 4'h1, 1'b1};
        vec[7]  = '{1'b0, 3'd7, 4'h0, 1'b1};
        vec[8]  = '{1'b1, 3'd6, 4'h0, 1'b0};
        vec[9]  = '{1'b1, 3'd7, 4'h0, 1'b0};
        vec[10] = '{1'b1, 3'd5, 4'hF, 1'b1};
        vec[11] = '{1'b1, 3'd0, 4'hA, 1'b1};

        rst = 1'b1;
        if8.d = 8'd89; if8.en = 1'b1; if8.mode = 1'b0; if8.s = 3'd0; if8.dwell = 8'd0;
        if6.d = 24'hFEDCBA; if6.en = 1'b1; if6.mode = 1'b0; if6.s = 3'd0; if6.dwell = 8'd0;

        // Reset values
        #12;
        check("rst_o8", 32'(if8.o), 32'd0);
        check("rst_v8", 32'(if8.o_valid), 32'd0);
        check("rst_sel8", 32'(if8.cur_sel), 32'd0);
        check("rst_wrp8", 32'(if8.wrap), 32'd0);
        check("rst_o6", 32'(if6.o), 32'd0);
        check("rst_v6", 32'(if6.o_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Manual select table, each setting held 10 cycles
        for (int i = 0; i < 12; i++) begin
            if (vec[i].dut6) if6.s = vec[i].s;
            else             if8.s = vec[i].s;
            for (int c = 0; c < 10; c++) begin
                push(vec[i].dut6, vec[i].o, vec[i].v, vec[i].s, 1'b0, "manual");
                tick();
            end
        end

        // Scan with dwell=2: each channel for 3 cycles, wrap every 24
        if8.dwell = 8'd2;
        if8.mode  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            sel = (i / 3) % 8;
            push(1'b0, {3'b000, m_d8[sel]}, 1'b1, 3'(sel), (i > 0 && i % 24 == 0), "scan_d2");
            tick();
        end

        // Back to manual for one cycle, then scan with dwell=0
        if8.mode = 1'b0; if8.s = 3'd0;
        push(1'b0, 4'h1, 1'b1, 3'd0, 1'b0, "to_man");
        tick();
        if8.dwell = 8'd0;
        if8.mode  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(1'b0, {3'b000, m_d8[i]}, 1'b1, 3'(i), 1'b0, "scan_d0");
            tick();
        end

        // Freeze 3 cycles at channel 3
        if8.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(1'b0, {3'b000, m_d8[3]}, 1'b0, 3'd3, 1'b0, "freeze");
            tick();
        end
        if8.en = 1'b1;
        for (int i = 4; i < 14; i++) begin
            sel = i % 8;
            push(1'b0, {3'b000, m_d8[sel]}, 1'b1, 3'(sel), (i == 8), "resume");
            tick();
        end

        // Asynchronous reset between edges at channel 5
        check("pre_rst", 32'(if8.cur_sel), 32'd5);
        #3;
        rst = 1'b1;
        #1;
        check("arst_o", 32'(if8.o), 32'd0);
        check("arst_v", 32'(if8.o_valid), 32'd0);
        check("arst_sel", 32'(if8.cur_sel), 32'd0);
        check("arst_wrp", 32'(if8.wrap), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(1'b0, {3'b000, m_d8[i]}, 1'b1, 3'(i), 1'b0, "post_rst");
            tick();
        end

        // Scan to manual, then en=0 together with mode=1: en wins
        if8.mode = 1'b0; if8.s = 3'd6;
        push(1'b0, 4'h1, 1'b1, 3'd6, 1'b0, "scan2man");
        tick();
        if8.en = 1'b0; if8.mode = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push(1'b0, 4'h1, 1'b0, 3'd6, 1'b0, "en_wins");
            tick();
        end
        if8.en = 1'b1;
        push(1'b0, 4'h1, 1'b1, 3'd0, 1'b0, "entry");
        tick();
        push(1'b0, 4'h0, 1'b1, 3'd1, 1'b0, "entry+1");
        tick();

        // Live dwell drop below dwell_cnt: step only after the 8-bit counter wraps
        if8.mode = 1'b0;
        push(1'b0, 4'h1, 1'b1, 3'd6, 1'b0, "to_man2");
        tick();
        if8.dwell = 8'd10;
        if8.mode  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push(1'b0, {3'b000, m_d8[0]}, 1'b1, 3'd0, 1'b0, "dwell10");
            tick();
        end
        if8.dwell = 8'd2;
        for (int i = 6; i < 264; i++) begin
            sel = (i < 259) ? 0 : ((i < 262) ? 1 : 2);
            push(1'b0, {3'b000, m_d8[sel]}, 1'b1, 3'(sel), 1'b0, "dwellcut");
            tick();
        end

`ifdef MUX_PARITY_EN
        // Parity of the selected 4-bit channel
        if6.s = 3'd1;
        push(1'b1, 4'hB, 1'b1, 3'd1, 1'b0, "par_sel");
        tick();
        check("par_1011", 32'(if6.o_par), 32'd1);
        if6.d = 24'hFED9BA;
        if6.s = 3'd2;
        push(1'b1, 4'h9, 1'b1, 3'd2, 1'b0, "par_sel2");
        tick();
        check("par_1001", 32'(if6.o_par), 32'd0);
        if6.s = 3'd6;
        push(1'b1, 4'h0, 1'b0, 3'd6, 1'b0, "par_oor");
        tick();
        check("par_oor", 32'(if6.o_par), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mux_nto1_scan.md
Name: mux_nto1_scan

Overview:
- Parametrised, registered N-to-1 multiplexer. Generalises the 8-to-1 single-bit mux to N channels of W bits each.
- Adds an auto-scan sequencer that steps through the channels with a programmable dwell time, plus an output-valid flag.
- Feeds the datapath test fabric, where one sampled channel drives a shared bus or LED/debug output.

Parameters:
- N, 8, number of input channels (2..256; need not be a power of two).
- W, 1, bits per channel.
- SW, $clog2(N), select width (derived; do not override).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- d  in  N*W  packed channel data; channel k = d[k*W +: W].
- en  in  1  global enable; low freezes all state.
- mode  in  1  0 = manual select, 1 = auto-scan.
- s  in  SW  manual channel select.
- dwell  in  8  scan dwell; each channel is held dwell+1 cycles.
- o  out  W  registered selected data.
- o_valid  out  1  o holds a valid sample this cycle.
- cur_sel  out  SW  channel currently presented on o.
- wrap  out  1  one-cycle pulse when scan steps from N-1 back to 0.

Behaviour:
- Reset (async, active-high): o=0, o_valid=0, cur_sel=0, wrap=0, scan channel counter=0, dwell counter=0. Takes effect immediately, mid-operation included; the first sample after rst falls is taken on the next enabled edge.
- All outputs are registered. Latency is one clock from d/s change to o.
- en=0: o, cur_sel, and both counters hold; o_valid <= 0; wrap <= 0.
- Manual mode, en=1, mode=0:
  - sel = s; o <= channel[sel]; cur_sel <= sel; o_valid <= 1.
  - Scan counters are held at 0.
- s >= N (non-power-of-two N): o <= 0, o_valid <= 0, cur_sel <= s.
- Scan mode, en=1, mode=1, two-counter sequencer with states HOLD and STEP:
  - HOLD: o <= channel[ch], cur_sel <= ch, o_valid <= 1. dwell_cnt increments each cycle.
  - When dwell_cnt == dwell: next cycle ch <= (ch == N-1) ? 0 : ch+1, and dwell_cnt <= 0.
  - wrap <= 1 on the same edge as the N-1 to 0 step; 0 otherwise.
  - dwell=0: channel advances every cycle.
  - dwell sampled live: a change applies to the current comparison. If the new dwell is below dwell_cnt, the step happens when the 8-bit dwell_cnt wraps to match.
- Mode change 0 to 1: ch <= 0, dwell_cnt <= 0. The first scan output is channel 0, one cycle later.
- Mode change 1 to 0: manual selection takes effect on the next edge. Scan counters clear.
- en and mode changes on the same edge: en=0 wins, so nothing advances. The mode-entry clear happens on the first enabled edge with mode=1.
- Only ch wraps modulo N. dwell_cnt is 8 bits and never exceeds 255.

Optional Feature:
- Macro: MUX_PARITY_EN.
- Defined: extra output port o_par (1 bit), equal to the registered even parity (XOR-reduce) of the selected channel. It is updated on the same edge as o. It resets to 0, is held when en=0, and is 0 when s >= N.
- Undefined: o_par port and parity logic are absent. All other behaviour is identical.

Test Plan:
- N=8, W=1, d=8'd89 (01011001), mode=0, en=1, sweep s=0..7, 100 ns each. Expect o = 1,0,0,1,1,0,1,0 one clock after each s change, o_valid=1, cur_sel=s.
- N=8, W=1, d=89, mode=1, dwell=2. Expect cur_sel 0,0,0,1,1,1,...,7,7,7,0. wrap is a 1-cycle pulse exactly when cur_sel goes 7 to 0 (every 24 cycles). o tracks the bits above.
- N=6, W=4, d={4'hF,4'hE,4'hD,4'hC,4'hB,4'hA}, mode=0, s=6 then s=7. Expect o=0, o_valid=0. Then s=5: o=4'hF, o_valid=1.
- Scan running with dwell=0, pulse en low for 3 cycles at cur_sel=3. Expect o/cur_sel frozen at 3 and o_valid=0 during the freeze. Resume with cur_sel=4 on the first enabled edge.
- Assert rst asynchronously mid-scan at cur_sel=5, between clock edges. Expect o, o_valid, cur_sel, and wrap to go to 0 immediately without a clock. After release, scan restarts from channel 0.
- MUX_PARITY_EN defined, W=4, select channel holding 4'b1011. Expect o_par=1. Channel 4'b1001: o_par=0.
